// File: rtl/uart_pkg.sv
// Shared UART definitions: RX state encoding, legal prescale values, parity types.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    RX_IDLE   = ST_IDLE,
    RX_START  = ST_START,
    RX_DATA   = ST_DATA,
    RX_PARITY = ST_PARITY,
    RX_STOP   = ST_STOP
  } rx_state_e;

  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Two-out-of-three vote used to reject single-sample noise on the line.
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling: edge counter, three taps around mid-bit, majority vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic               clr,
  input  logic [PRESC_W-1:0] prescale,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic               bit_val,
  output logic               sample_valid
);

  logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [2:0]         taps_q, taps_d;
  logic               sample_valid_q, sample_valid_d;
  logic [PRESC_W-1:0] half;

  assign half = prescale >> 1;

  // Next edge count and tap captures at P/2-1, P/2, P/2+1; strobe marks vote ready.
  always_comb begin
    edge_cnt_d     = edge_cnt_q + PRESC_W'(1);
    taps_d         = taps_q;
    sample_valid_d = 1'b0;
    if (clr || (edge_cnt_q == prescale - PRESC_W'(1))) begin
      edge_cnt_d = '0;
    end
    if (edge_cnt_q == half - PRESC_W'(1)) taps_d[0] = rx_in;
    if (edge_cnt_q == half)               taps_d[1] = rx_in;
    if (edge_cnt_q == half + PRESC_W'(1)) begin
      taps_d[2]      = rx_in;
      sample_valid_d = !clr;
    end
  end

  // Sampler registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_q     <= '0;
      taps_q         <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      edge_cnt_q     <= edge_cnt_d;
      taps_q         <= taps_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign edge_cnt     = edge_cnt_q;
  assign bit_val      = majority3(taps_q);
  assign sample_valid = sample_valid_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive deframer: start validation, LSB-first data, optional parity, stop check.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RX_IDLE   | line idle, waiting for a low level to start a frame
// RX_START  | start bit; a high majority vote aborts back to idle
// RX_DATA   | DATA_WIDTH data bits shifted in LSB first
// RX_PARITY | parity bit compared against the received data
// RX_STOP   | stop bit; on its last edge exactly one outcome is reported
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err,
  output logic                  Busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  rx_state_e             state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bad_q, par_bad_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;
  logic                  busy_q, busy_d;

  logic [PRESC_W-1:0]    edge_cnt;
  logic                  bit_val;
  logic                  sample_valid;
  logic                  smp_clr;
  logic                  last_edge;

  // Edge counter restarts on every state entry and is held at zero while idle.
  assign smp_clr   = (state_d != state_q) || (state_q == RX_IDLE);
  assign last_edge = (edge_cnt == presc_q - PRESC_W'(1));

  uart_rx_sampler #(
    .PRESC_W (PRESC_W)
  ) u_sampler (
    .clk          (CLK),
    .rst          (RST),
    .rx_in        (RX_IN),
    .clr          (smp_clr),
    .prescale     (presc_q),
    .edge_cnt     (edge_cnt),
    .bit_val      (bit_val),
    .sample_valid (sample_valid)
  );

  // Frame FSM next-state, datapath and outcome decisions.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    presc_d   = presc_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    p_data_d  = p_data_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!RX_IN) begin
          state_d   = RX_START;
          presc_d   = Prescale;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
        end
      end
      RX_START: begin
        if (sample_valid && bit_val) begin
          state_d = RX_IDLE;
        end else if (last_edge) begin
          state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (sample_valid) begin
          shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
        end
        if (last_edge) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = par_en_q ? RX_PARITY : RX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      RX_PARITY: begin
        if (sample_valid) begin
          par_bad_d = (bit_val != ((^shift_q) ^ par_typ_q));
        end
        if (last_edge) begin
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (last_edge) begin
          state_d = RX_IDLE;
          if (!bit_val) begin
            se_d = 1'b1;
          end else if (par_bad_q) begin
            pe_d = 1'b1;
          end else begin
            p_data_d = shift_q;
            dv_d     = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
    busy_d = (state_d != RX_IDLE);
  end

  // All frame state and registered outputs; reset drops any partial frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      p_data_q  <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      p_data_q  <= p_data_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
      busy_q    <= busy_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = dv_q;
  assign Par_Err    = pe_q;
  assign Stp_Err    = se_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame. Latencies are counted as the k-th cycle
// after the edge at which the idle receiver first sees the start bit low.
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] Prescale;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          Par_Err;
  logic          Stp_Err;
  logic          Busy;

  int checks   = 0;
  int failures = 0;

  int cyc        = 0;
  int dv_total   = 0;
  int pe_total   = 0;
  int se_total   = 0;
  int busy_total = 0;
  int pdata_bad  = 0;
  int pe_cyc     = 0;
  int se_cyc     = 0;
  int dv_cyc [16];
  logic [7:0] dv_dat [16];
  logic       rst_at_edge = 1'b1;
  logic [7:0] pdata_prev  = 8'h00;

  always #5 CLK = ~CLK;

  uart_rx_frame #(
    .DATA_WIDTH (DW),
    .PRESC_W    (PW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Par_Err    (Par_Err),
    .Stp_Err    (Stp_Err),
    .Busy       (Busy)
  );

  always @(posedge CLK) begin
    cyc         <= cyc + 1;
    rst_at_edge <= RST;
  end

  // Pulse logger sampled mid-cycle.
  always @(negedge CLK) begin
    if (Data_Valid) begin
      if (dv_total < 16) begin
        dv_cyc[dv_total] <= cyc;
        dv_dat[dv_total] <= P_DATA;
      end
      dv_total <= dv_total + 1;
    end
    if (Par_Err) begin
      pe_cyc   <= cyc;
      pe_total <= pe_total + 1;
    end
    if (Stp_Err) begin
      se_cyc   <= cyc;
      se_total <= se_total + 1;
    end
    if (Busy) busy_total <= busy_total + 1;
    if (!rst_at_edge && (P_DATA !== pdata_prev) && !Data_Valid) pdata_bad <= pdata_bad + 1;
    pdata_prev <= P_DATA;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; holds the line for p cycles.
  task automatic drive_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input int p, input bit pen,
                            input bit par_bit, input bit stop_bit, output int t0);
    t0 = cyc;
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(data[i], p);
    if (pen) drive_bit(par_bit, p);
    drive_bit(stop_bit, p);
    RX_IN = 1'b1;
  endtask

  initial begin
    int t0, t1, b_dv, b_pe, b_se, b_busy, span;

    RST      = 1'b1;
    RX_IN    = 1'b1;
    Prescale = 6'(PRESC_8);
    PAR_EN   = 1'b0;
    PAR_TYP  = PAR_EVEN;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_pdata", int'(P_DATA), 0);
    check("rst_outs", int'({Data_Valid, Par_Err, Stp_Err, Busy}), 0);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Good 8E1 frame, P=8: 0xA5 has four ones, even parity bit 0.
    PAR_EN = 1'b1; PAR_TYP = PAR_EVEN; Prescale = 6'(PRESC_8);
    b_dv = dv_total; b_pe = pe_total; b_se = se_total;
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, t0);
    repeat (4) @(posedge CLK);
    #1;
    check("good_dv_count", dv_total - b_dv, 1);
    check("good_latency", dv_cyc[b_dv] - t0, 89);
    check("good_data", int'(dv_dat[b_dv]), 'hA5);
    check("good_pdata_hold", int'(P_DATA), 'hA5);
    check("good_no_err", (pe_total - b_pe) + (se_total - b_se), 0);

    // Same frame with wrong parity bit.
    b_dv = dv_total; b_pe = pe_total; b_se = se_total;
    send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1, t0);
    repeat (4) @(posedge CLK);
    #1;
    check("par_err_count", pe_total - b_pe, 1);
    check("par_err_latency", pe_cyc - t0, 89);
    check("par_no_dv", dv_total - b_dv, 0);
    check("par_no_stp", se_total - b_se, 0);
    check("par_pdata_kept", int'(P_DATA), 'hA5);

    // 8N1 at P=16 with stop bit low.
    PAR_EN = 1'b0; Prescale = 6'(PRESC_16);
    b_dv = dv_total; b_pe = pe_total; b_se = se_total;
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, t0);
    repeat (4) @(posedge CLK);
    #1;
    check("stp_err_count", se_total - b_se, 1);
    check("stp_err_latency", se_cyc - t0, 161);
    check("stp_no_dv", dv_total - b_dv, 0);
    check("stp_no_par", pe_total - b_pe, 0);
    check("stp_pdata_kept", int'(P_DATA), 'hA5);

    // Two-cycle low glitch at P=8.
    Prescale = 6'(PRESC_8);
    b_dv = dv_total; b_pe = pe_total; b_se = se_total; b_busy = busy_total;
    RX_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    span = busy_total - b_busy;
    check("glitch_busy_span", int'(span >= 1 && span <= 7), 1);
    check("glitch_no_pulse", (dv_total - b_dv) + (pe_total - b_pe) + (se_total - b_se), 0);
    check("glitch_idle", int'(Busy), 0);

    // Back-to-back 8N1 at P=32.
    Prescale = 6'(PRESC_32);
    b_dv = dv_total; b_pe = pe_total; b_se = se_total;
    send_frame(8'h00, 32, 1'b0, 1'b0, 1'b1, t0);
    send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b1, t1);
    repeat (4) @(posedge CLK);
    #1;
    check("b2b_dv_count", dv_total - b_dv, 2);
    check("b2b_first_latency", dv_cyc[b_dv] - t0, 321);
    check("b2b_gap", dv_cyc[b_dv + 1] - dv_cyc[b_dv], 321);
    check("b2b_data0", int'(dv_dat[b_dv]), 'h00);
    check("b2b_data1", int'(dv_dat[b_dv + 1]), 'hFF);
    check("b2b_no_err", (pe_total - b_pe) + (se_total - b_se), 0);

    // Reset during data bit 4 of an aborted 0x5A frame, then a clean 0x81.
    Prescale = 6'(PRESC_8);
    b_dv = dv_total; b_pe = pe_total; b_se = se_total;
    drive_bit(1'b0, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b1, 4);
    check("rst_mid_busy_before", int'(Busy), 1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_mid_pdata", int'(P_DATA), 0);
    check("rst_mid_outs", int'({Data_Valid, Par_Err, Stp_Err, Busy}), 0);
    RST = 1'b0;
    repeat (16) @(posedge CLK);
    #1;
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, t0);
    repeat (4) @(posedge CLK);
    #1;
    check("rst_mid_dv_count", dv_total - b_dv, 1);
    check("rst_mid_data", int'(dv_dat[b_dv]), 'h81);
    check("rst_mid_latency", dv_cyc[b_dv] - t0, 81);
    check("rst_mid_no_err", (pe_total - b_pe) + (se_total - b_se), 0);

    check("pdata_only_with_dv", pdata_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
